// File: rtl/tone_dac_driver_pkg.sv
// Shared constants and helpers for the tone DAC driver and its tone generator.
// Latency: n/a (package). Backpressure: n/a (package).
// Holds the divider/sample widths, amplitude step and rest code.
package tone_dac_driver_pkg;

    localparam int CNT_W    = 9;
    localparam int SAMPLE_W = 16;
    localparam int SOUND_W  = 20;
    localparam int VOL_W    = 3;

    localparam logic [SAMPLE_W-1:0] AMP_STEP  = 16'h0FFF;
    localparam logic [SOUND_W-1:0]  REST_NOTE = 20'd0;

    // 7 * 0x0FFF = 0x6FF9 stays below 0x8000, so the positive half never overflows.
    function automatic logic [SAMPLE_W-1:0] tone_amplitude(input logic [VOL_W-1:0] vol);
        logic [SAMPLE_W-1:0] vol_ext;
        vol_ext = {{(SAMPLE_W-VOL_W){1'b0}}, vol};
        return vol_ext * AMP_STEP;
    endfunction

endpackage

// File: rtl/square_tone_gen.sv
// Square-wave tone generator: half-period in clks from sound, amplitude from volume.
// Latency: sound registered one clk before use; sample is combinational from state.
// Backpressure: none; free-running, sample is consumed whenever the serializer loads.
module square_tone_gen
    import tone_dac_driver_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [SOUND_W-1:0]  sound,
    input  logic [VOL_W-1:0]    volume,
    input  logic                mute,
    output logic [SAMPLE_W-1:0] sample
);

    logic [SOUND_W-1:0]  note_q;
    logic [SOUND_W-1:0]  tone_cnt;
    logic                phase;
    logic                note_change;
    logic [SAMPLE_W-1:0] amplitude;

    assign note_change = (sound != note_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            note_q   <= REST_NOTE;
            tone_cnt <= '0;
            phase    <= 1'b0;
        end else begin
            note_q <= sound;
            // A new note restarts the wave at phase 0 so every note begins on a positive half.
            if (note_change || note_q == REST_NOTE) begin
                tone_cnt <= '0;
                phase    <= 1'b0;
            end else if (tone_cnt == note_q - 20'd1) begin
                tone_cnt <= '0;
                phase    <= ~phase;
            end else begin
                tone_cnt <= tone_cnt + 20'd1;
            end
        end
    end

    always_comb begin
        amplitude = tone_amplitude(volume);
        sample    = '0;
        if (!(mute || note_q == REST_NOTE || volume == '0)) begin
            sample = phase ? (~amplitude + 16'd1) : amplitude;
        end
    end

endmodule

// File: rtl/tone_dac_driver.sv
// I2S-style DAC driver: clock divider, tone generator and 16-bit MSB-first serializer.
// Latency: sample captured at cnt[7:0]==FF, bit 15 out for the next 16 clks.
// Backpressure: none; the DAC is a pure sink clocked from audio_sck/audio_lrck.
module tone_dac_driver
    import tone_dac_driver_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [SOUND_W-1:0] sound,
    input  logic [VOL_W-1:0]   volume,
    input  logic               mute,
    output logic               audio_mclk,
    output logic               audio_lrck,
    output logic               audio_sck,
    output logic               audio_sdin
);

    logic [CNT_W-1:0]    cnt;
    logic [SAMPLE_W-1:0] sample;
    logic [SAMPLE_W-1:0] shreg;

    square_tone_gen u_tone (
        .clk    (clk),
        .rst    (rst),
        .sound  (sound),
        .volume (volume),
        .mute   (mute),
        .sample (sample)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Load on the last clk of each lrck half; shift on each sck falling edge otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg <= '0;
        end else if (cnt[7:0] == 8'hFF) begin
            shreg <= sample;
        end else if (cnt[3:0] == 4'hF) begin
            shreg <= {shreg[SAMPLE_W-2:0], 1'b0};
        end
    end

    assign audio_mclk = cnt[1];
    assign audio_sck  = cnt[3];
    assign audio_lrck = cnt[8];
    assign audio_sdin = shreg[SAMPLE_W-1];

endmodule

// File: tb/tb_tone_dac_driver.sv
// Directed bench for tone_dac_driver with a cycle model feeding a word scoreboard.
module tb_tone_dac_driver;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [19:0] sound = '0;
    logic [2:0]  volume = '0;
    logic        mute = 1'b0;
    logic        audio_mclk, audio_lrck, audio_sck, audio_sdin;

    int checks = 0;
    int errors = 0;

    tone_dac_driver dut (
        .clk        (clk),
        .rst        (rst),
        .sound      (sound),
        .volume     (volume),
        .mute       (mute),
        .audio_mclk (audio_mclk),
        .audio_lrck (audio_lrck),
        .audio_sck  (audio_sck),
        .audio_sdin (audio_sdin)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: elapsed clks since the note started give tone_cnt and phase.
    logic [8:0]  m_cnt = '0;
    logic [19:0] m_note = '0;
    int          m_el = 0;
    logic [15:0] sbq[$];

    function automatic bit model_phase(input logic [19:0] n, input int el);
        if (n == 0) return 1'b0;
        return ((el / int'(n)) % 2) == 1;
    endfunction

    function automatic logic [19:0] model_tone_cnt(input logic [19:0] n, input int el);
        if (n == 0) return '0;
        return 20'(el % int'(n));
    endfunction

    function automatic logic [15:0] exp_sample(input logic [19:0] n, input bit ph,
                                               input logic [2:0] v, input logic m);
        int a;
        a = int'(v) * 4095;
        if (m || n == 0 || v == 0) return 16'h0000;
        return ph ? 16'(65536 - a) : 16'(a);
    endfunction

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_cnt = '0;
                m_note = '0;
                m_el = 0;
                sbq.delete();
            end else begin
                if (m_cnt[7:0] == 8'hFF)
                    sbq.push_back(exp_sample(m_note, model_phase(m_note, m_el), volume, mute));
                if (sound != m_note || m_note == 0) m_el = 0;
                else m_el++;
                m_note = sound;
                m_cnt = m_cnt + 9'd1;
            end
        end
    end

    // Monitor: alignment, tone state and bit collection, sampled at negedge.
    logic [15:0] col_word = '0;
    bit          collecting = 1'b0;
    logic [15:0] last_word = '0;
    bit          last_left = 1'b0;
    int          words_seen = 0;

    initial begin
        logic [15:0] exp_w;
        forever begin
            @(negedge clk);
            if (rst) begin
                collecting = 1'b0;
                chk("rst_outs", {audio_mclk, audio_lrck, audio_sck, audio_sdin}, 4'b0000);
            end else begin
                chk("clk_align", {audio_mclk, audio_sck, audio_lrck}, {m_cnt[1], m_cnt[3], m_cnt[8]});
                chk("tone_cnt", dut.u_tone.tone_cnt, model_tone_cnt(m_note, m_el));
                chk("phase", dut.u_tone.phase, model_phase(m_note, m_el));
                if (m_cnt[3:0] == 4'h8) begin
                    if (m_cnt[7:4] == 4'h0) begin
                        col_word = '0;
                        collecting = 1'b1;
                    end
                    col_word = {col_word[14:0], audio_sdin};
                    if (m_cnt[7:4] == 4'hF && collecting) begin
                        exp_w = (sbq.size() > 0) ? sbq.pop_front() : 16'h0000;
                        chk("word", col_word, exp_w);
                        last_word = col_word;
                        last_left = m_cnt[8];
                        words_seen++;
                        collecting = 1'b0;
                    end
                end
            end
        end
    end

    task automatic wait_cnt(input logic [8:0] target, input int budget);
        int n = 0;
        while (m_cnt != target && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("wait_cnt", m_cnt, target);
    endtask

    task automatic wait_word(input int budget, output logic [15:0] w, output bit left);
        int n = 0;
        int start = words_seen;
        while (words_seen == start && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (words_seen == start) chk("wait_word_timeout", 0, 1);
        w = last_word;
        left = last_left;
    endtask

    task automatic count_sdin_high(input int ncyc, output int hits);
        hits = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (audio_sdin !== 1'b0) hits++;
        end
    endtask

    initial begin
        logic [15:0] w;
        bit          left;
        int          hits, r_mclk, r_sck, r_lrck, n;
        logic        p_mclk, p_sck, p_lrck;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_mclk", audio_mclk, 1'b0);
        chk("rst_lrck", audio_lrck, 1'b0);
        chk("rst_sck", audio_sck, 1'b0);
        chk("rst_sdin", audio_sdin, 1'b0);
        #2 rst = 1'b0;

        // Clock ratios over 2048 clks
        r_mclk = 0; r_sck = 0; r_lrck = 0;
        p_mclk = audio_mclk; p_sck = audio_sck; p_lrck = audio_lrck;
        for (int i = 0; i < 2048; i++) begin
            @(negedge clk);
            if (audio_mclk && !p_mclk) r_mclk++;
            if (audio_sck && !p_sck) r_sck++;
            if (audio_lrck && !p_lrck) r_lrck++;
            p_mclk = audio_mclk; p_sck = audio_sck; p_lrck = audio_lrck;
        end
        chk("mclk_rises", r_mclk, 512);
        chk("sck_rises", r_sck, 128);
        chk("lrck_rises", r_lrck, 4);

        // Basic tone
        sound = 20'd4; volume = 3'd1; mute = 1'b0;
        repeat (2) wait_word(600, w, left);
        for (int i = 0; i < 4; i++) begin
            wait_word(600, w, left);
            chk("tone_word_set", (w == 16'h0FFF || w == 16'hF001), 1);
        end

        // Rest, then mute
        sound = 20'd0; volume = 3'd7;
        repeat (512) @(negedge clk);
        count_sdin_high(2048, hits);
        chk("rest_silent", hits, 0);
        sound = 20'd30303; mute = 1'b1;
        repeat (512) @(negedge clk);
        count_sdin_high(2048, hits);
        chk("mute_silent", hits, 0);

        // Max amplitude: first left word after the note change
        mute = 1'b0;
        wait_cnt(9'd300, 600);
        sound = 20'd300000; volume = 3'd7;
        wait_cnt(9'd0, 600);
        left = 1'b0;
        for (int i = 0; i < 3 && !left; i++) wait_word(600, w, left);
        chk("max_left_is_left", left, 1'b1);
        chk("max_left_word", w, 16'h6FF9);

        // Note change at tone_cnt == 1000
        sound = 20'd40486;
        n = 0;
        while (!(m_note == 20'd40486 && m_el == 1000) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("nc_tone_cnt_1000", dut.u_tone.tone_cnt, 20'd1000);
        sound = 20'd38167;
        @(negedge clk);
        chk("nc_cleared_cnt", dut.u_tone.tone_cnt, 20'd0);
        chk("nc_cleared_phase", dut.u_tone.phase, 1'b0);
        n = 0;
        while (dut.u_tone.phase !== 1'b1 && n < 40000) begin
            @(negedge clk);
            n++;
        end
        chk("nc_half_period", n, 38167);

        // Reset mid-word
        sound = 20'd5000; volume = 3'd3;
        repeat (600) @(negedge clk);
        wait_cnt(9'd200, 600);
        #2 rst = 1'b1;
        #1;
        chk("midrst_outs", {audio_mclk, audio_lrck, audio_sck, audio_sdin}, 4'b0000);
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        wait_cnt(9'd255, 600);
        chk("midrst_no_partial", audio_sdin, 1'b0);
        repeat (3) wait_word(600, w, left);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tone_dac_driver.md
TONE_DAC_DRIVER -- requirements
Module: tone_dac_driver

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all logic on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port sound, input, 20 bits: tone half-period in clk cycles; 0 = rest (silence).
REQ-004 SHALL have port volume, input, 3 bits: amplitude step, 0 = silent, 7 = loudest.
REQ-005 SHALL have port mute, input, 1 bit: forces sample to 0 while high.
REQ-006 SHALL have port audio_mclk, output, 1 bit: DAC master clock, clk/4.
REQ-007 SHALL have port audio_lrck, output, 1 bit: channel select, clk/512; high = left, low = right.
REQ-008 SHALL have port audio_sck, output, 1 bit: serial bit clock, clk/16.
REQ-009 SHALL have port audio_sdin, output, 1 bit: serial sample data, MSB first.

Function
REQ-010 SHALL contain a 9-bit free-running divider cnt, incrementing every clk and wrapping 511->0.
REQ-011 SHALL drive audio_mclk = cnt[1], audio_sck = cnt[3] and audio_lrck = cnt[8].
REQ-012 SHALL register sound into note_q every clk.
REQ-013 SHALL, when sound != note_q (note change), clear tone_cnt to 0 and phase to 0 on that edge.
REQ-014 SHALL, when note_q != 0 and no note change occurs, increment a 20-bit tone_cnt each clk.
REQ-015 SHALL, when tone_cnt == note_q-1, clear tone_cnt and toggle phase, so the square wave period is 2*note_q clks.
REQ-016 SHALL, when note_q == 0, hold tone_cnt = 0 and phase = 0.
REQ-017 SHALL compute amplitude as volume * 16'h0FFF (max 16'h6FF9, always positive in 16-bit two's complement).
REQ-018 SHALL compute the sample as follows: 0 if mute, or note_q == 0, or volume == 0; otherwise +amplitude when phase = 0 and -amplitude (two's complement) when phase = 1.
REQ-019 SHALL, on the edge where cnt[7:0] == 8'hFF, load the current sample into a 16-bit shift register; the same sample goes to both channels.
REQ-020 SHALL, otherwise, shift the register left by one, inserting 0, on the edge where cnt[3:0] == 4'hF (the sck falling edge).
REQ-021 SHALL drive audio_sdin from the shift register MSB, so that sample bit 15 is valid during the first sck period of each lrck half and bit 0 during the 16th.
REQ-022 SHALL treat sound, volume and mute changes as taking effect on the serial stream at the next frame-half load only; no glitch occurs within a word.

Reset
REQ-023 SHALL, while rst is high, clear cnt, note_q, tone_cnt, phase and the shift register to 0.
REQ-024 SHALL, while rst is high, hold all four audio_* outputs at 0.
REQ-025 SHALL resume from cnt = 0 on the first clk after rst deasserts; reset mid-word aborts that word with no partial bits retained.

Structure
REQ-026 SHALL place the divider width (9), the sample width (16), the step constant 16'h0FFF and the rest code (20'd0) in the shared audio package.
REQ-027 SHALL implement the tone generator (REQ-012 to REQ-018) as sub-module square_tone_gen; the serializer and divider remain in tone_dac_driver.

Verification
REQ-028 SHALL cover clock ratios: after reset, run 2048 clks -> mclk period 4, sck period 16, lrck period 512, all edges aligned to cnt.
REQ-029 SHALL cover a basic tone: sound = 4, volume = 1, mute = 0 -> phase toggles every 4 clks; serialized words are 16'h0FFF or 16'hF001 only.
REQ-030 SHALL cover rest and mute: sound = 0 with volume = 7, then sound = 30303 with mute = 1 -> audio_sdin stays 0 for 4 frames.
REQ-031 SHALL cover max amplitude: sound = 20'd300000, volume = 7 -> the first left word after a note change is 16'h6FF9, MSB first, bit 15 during sck period 1.
REQ-032 SHALL cover a note change: switch sound from 40486 to 38167 at tone_cnt = 1000 -> tone_cnt = 0 and phase = 0 on the next edge, and the new half-period = 38167 clks.
REQ-033 SHALL cover reset mid-word: assert rst at cnt = 200 for 3 clks -> outputs 0 during reset; first loaded word at cnt = 255 after release.
